switch_input_reader: RTL



---
 rtl/switch_input_reader_pkg.sv | 11 +
 rtl/switch_input_reader_if.sv | 13 +
 rtl/switch_input_reader_debounce_bit.sv | 45 ++++
 rtl/switch_input_reader.sv | 80 ++++++++
 4 files changed

// File: rtl/switch_input_reader_pkg.sv
// Shared read-map constants and bus word type for the switch/button input reader.
package switch_input_reader_pkg;

  localparam int DATA_W = 32;

  localparam logic ADDR_DATA  = 1'b0;
  localparam logic ADDR_EVENT = 1'b1;

  typedef logic [DATA_W-1:0] rd_word_t;

endpackage

// File: rtl/switch_input_reader_if.sv
// CPU-side read port of the input reader; master is the CPU, slave is the peripheral.
interface switch_input_reader_if;
  import switch_input_reader_pkg::*;

  logic     rd_en;
  logic     rd_addr;
  rd_word_t rd_data;
  logic     irq;

  modport master (output rd_en, output rd_addr, input rd_data, input irq);
  modport slave  (input rd_en, input rd_addr, output rd_data, output irq);

endinterface

// File: rtl/switch_input_reader_debounce_bit.sv
// One input bit: 2-flop synchroniser, stability counter and accepted value, plus a 0->1 accept pulse.
// A clean transition reaches stable DEBOUNCE_CYCLES+2 edges after it is first sampled; no backpressure.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic stable,
  output logic rise
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [1:0]           sync_q;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 s;
  logic                 accept;

  // Counter only runs while the synced level disagrees with s, so it never exceeds CNT_LAST.
  assign accept = (sync_q[1] != s) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      cnt    <= '0;
      s      <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      if (sync_q[1] == s) begin
        cnt <= '0;
      end else if (accept) begin
        s   <= sync_q[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stable = s;
  assign rise   = accept & sync_q[1];

endmodule

// File: rtl/switch_input_reader.sv
// Debounced switch/button reader exposed as a 2-word read-only CPU peripheral; rd_data one cycle after rd_en, never stalls.
// Optional registered event interrupt under SWITCH_INPUT_IRQ_EN; without it irq is tied low.
module switch_input_reader
  import switch_input_reader_pkg::*;
#(
  parameter int SW_WIDTH        = 8,
  parameter int BTN_WIDTH       = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  sw,
  input  logic [BTN_WIDTH-1:0] btn,
  switch_input_reader_if.slave bus
);

  localparam int NUM_IN = SW_WIDTH + BTN_WIDTH;

  logic [NUM_IN-1:0]    pins;
  logic [NUM_IN-1:0]    stable;
  logic [NUM_IN-1:0]    rise;
  logic [SW_WIDTH-1:0]  sw_rise_unused;
  logic [BTN_WIDTH-1:0] btn_rise;
  logic [BTN_WIDTH-1:0] ev;
  rd_word_t             rd_data_q;
  logic                 ev_clear;

  // Packing order matches the DATA word layout: buttons above switches.
  assign pins = {btn, sw};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_db (
      .clk   (clk),
      .rst   (rst),
      .pin   (pins[i]),
      .stable(stable[i]),
      .rise  (rise[i])
    );
  end

  assign sw_rise_unused = rise[SW_WIDTH-1:0];
  assign btn_rise       = rise[NUM_IN-1:SW_WIDTH];
  assign ev_clear       = bus.rd_en && (bus.rd_addr == ADDR_EVENT);

  // A press landing on the clearing edge survives: the clear only drops what was returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      ev        <= '0;
      rd_data_q <= '0;
    end else begin
      if (bus.rd_en) begin
        rd_data_q <= (bus.rd_addr == ADDR_EVENT) ? DATA_W'(ev) : DATA_W'(stable);
      end
      ev <= (ev_clear ? '0 : ev) | btn_rise;
    end
  end

  assign bus.rd_data = rd_data_q;

`ifdef SWITCH_INPUT_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |ev;
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule
